// File: rtl/key_command_scheduler_if.sv
// Command handshake between the key scheduler (master) and the game FSM (slave).
// The consumer takes the head command when cmd_valid && cmd_ready.
interface key_command_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/key_command_scheduler.sv
// Turns PS/2 key make edges into one-shot game commands queued in a small FIFO.
// Optional auto-repeat of the last pressed key is built when AUTO_REPEAT_EN is defined.
module key_command_scheduler #(
  parameter int DEPTH         = 4,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_PERIOD = 10000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [2:0]                     key_i,
  input  logic                           key_state_i,
  input  logic                           enable_i,
  input  logic                           flush_i,
  key_command_scheduler_if.master        cmd_if,
  output logic [4:0]                     held_o,
  output logic                           overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [3:0]    prev_q;
  logic [4:0]    held_q, held_d;
  logic          overflow_q;
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic       key_ok, key_event, fresh_make, key_break;
  logic       press_push, rep_push, push_req, push_ok, pop;
  logic [4:0] key_oh;
  logic [2:0] rep_cmd, push_cmd;

  always_comb begin
    key_ok = (key_i >= 3'd1) && (key_i <= 3'd5);
    key_oh = '0;
    if (key_ok) key_oh = 5'd1 << (key_i - 3'd1);
    key_event  = key_ok && ({key_i, key_state_i} != prev_q);
    fresh_make = key_event && key_state_i && ((held_q & key_oh) == '0);
    key_break  = key_event && !key_state_i;
    press_push = fresh_make && enable_i;
    held_d = held_q;
    if (key_event) held_d = key_state_i ? (held_q | key_oh) : (held_q & ~key_oh);
  end

`ifdef AUTO_REPEAT_EN
  // state      | meaning
  // REP_IDLE   | no key being auto-repeated
  // REP_DELAY  | rep_key held, waiting out the initial delay
  // REP_REPEAT | rep_key held, pushing once per period
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [RCW-1:0] DELAY_LD  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LD = RCW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {REP_IDLE, REP_DELAY, REP_REPEAT} rep_state_e;
  rep_state_e     rep_state_q;
  logic [2:0]     rep_key_q;
  logic [RCW-1:0] rep_cnt_q;

  // Terminal count doubles as the repeat tick; a simultaneous press push wins.
  assign rep_push = (rep_state_q != REP_IDLE) && (rep_cnt_q == '0) && enable_i && !press_push;
  assign rep_cmd  = rep_key_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_state_q <= REP_IDLE;
      rep_key_q   <= '0;
      rep_cnt_q   <= '0;
    end else if (key_break && key_i == rep_key_q && rep_state_q != REP_IDLE) begin
      rep_state_q <= REP_IDLE;
    end else if (press_push) begin
      rep_state_q <= REP_DELAY;
      rep_key_q   <= key_i;
      rep_cnt_q   <= DELAY_LD;
    end else begin
      case (rep_state_q)
        REP_DELAY, REP_REPEAT: begin
          if (rep_cnt_q == '0) begin
            rep_state_q <= REP_REPEAT;
            rep_cnt_q   <= PERIOD_LD;
          end else begin
            rep_cnt_q <= rep_cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign rep_push = 1'b0;
  assign rep_cmd  = '0;
`endif

  always_comb begin
    push_req = press_push || rep_push;
    push_cmd = press_push ? key_i : rep_cmd;
    pop      = (count_q != '0) && cmd_if.cmd_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    push_ok  = push_req && ((count_q != FULL_CNT) || pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q     <= '0;
      held_q     <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      prev_q <= {key_i, key_state_i};
      held_q <= held_d;
      if (flush_i) begin
        overflow_q <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push_req && !push_ok) overflow_q <= 1'b1;
        if (push_ok && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push_ok) count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_ok) mem_q[wr_ptr_q] <= push_cmd;
  end

  assign cmd_if.cmd_valid = (count_q != '0);
  assign cmd_if.cmd       = (count_q != '0) ? mem_q[rd_ptr_q] : 3'd0;
  assign held_o           = held_q;
  assign overflow_o       = overflow_q;

endmodule
